int_to_fp_seq: RTL and testbench
================================

Name: int_to_fp_seq

Overview:
- Multicycle, handshaked integer-to-floating-point converter; successor to the single-cycle converter.
- Parametrised in integer width and FP format.
- Per-transaction signed/unsigned mode and rounding mode (RNE / RTZ).
- Correct handling of the most-negative integer, format overflow and inexact/overflow flags.
- Sits between integer ALU results and the FPU operand path; valid/ready on both sides.

Parameters:
- int_size, 32, integer input width (>= 2)
- exponent_size, 8, FP exponent field width
- mantissa_size, 23, FP stored-fraction width
- precision, 1+exponent_size+mantissa_size, FP word width (derived, do not override)
- exp_bias, 2^(exponent_size-1)-1, exponent bias (derived)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  converter can accept; high only in IDLE
- int_in  in  int_size  integer operand
- is_signed  in  1  1: int_in is two's complement; 0: unsigned
- rnd_mode  in  1  0: round-nearest-even; 1: round-toward-zero
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts result
- fp  out  precision  result {sign, exponent, fraction}
- inexact  out  1  result != exact value; valid with out_valid
- overflow  out  1  magnitude exceeded format; valid with out_valid

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, fp=0, inexact=0, overflow=0, internal regs cleared. Reset in any state (mid-NORM, DONE with pending result) aborts and drops the transaction.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid:
  - Capture sign = is_signed & int_in[msb].
  - Capture mag = sign ? two's-negate(int_in) : int_in, int_size bits unsigned. Signed most-negative value yields mag = 2^(int_size-1), exact.
  - Capture rnd_mode and exp_cnt = int_size-1.
  - If int_in == 0: load fp=+0 (sign 0, even for signed), flags 0, go DONE. Else go NORM.
- NORM: one cycle per step.
  - If mag[msb]=0: mag <= mag<<1, exp_cnt <= exp_cnt-1, stay.
  - Else go ROUND.
  - Occupancy = lz+1 cycles, where lz is the leading-zero count of mag.
- ROUND, single cycle:
  - frac = mag[int_size-2 downto int_size-1-mantissa_size], zero-padded on the right if int_size-1 < mantissa_size.
  - guard = next lower bit (0 if none); sticky = OR of remaining lower bits.
  - inexact = guard | sticky.
  - RNE: increment frac if guard & (sticky | frac[0]). RTZ: never increment.
  - Fraction carry-out: frac=0, exp_cnt+1.
  - biased = exp_bias + exp_cnt, computed wide enough to not wrap.
  - If biased >= 2^exponent_size - 1: overflow=1, inexact=1.
    - RNE result: +/-infinity (exp all ones, frac 0).
    - RTZ result: +/- largest finite (exp all-ones minus 1, frac all ones).
  - Otherwise fp = {sign, biased, frac}. Go DONE.
- DONE: out_valid=1; fp and flags stable. On out_ready: out_valid <= 0, go IDLE.
  - No new input is accepted in the same cycle; in_ready rises next cycle.
- Latency, in cycles from the accepting edge to out_valid high:
  - Nonzero input: lz+3.
  - Zero input: 1.
- Throughput: one transaction in flight; in_ready=0 in NORM, ROUND and DONE.
- in_valid while busy is ignored (no capture). Input values are not required stable after acceptance.
- Denormal outputs cannot occur; integers never underflow.

Test Plan:
- Default params, is_signed=1, RNE, int_in=1 → fp=0x3F800000, inexact=0, out_valid 34 cycles after accept.
- int_in=0xFFFFFFFF:
  - is_signed=1 → 0xBF800000, exact.
  - is_signed=0 → 0x4F800000 (2^32), inexact=1.
- int_in=0x80000000, is_signed=1 → 0xCF000000, inexact=0, overflow=0.
- int_in=16777217:
  - RNE → 0x4B800000, inexact=1.
  - RTZ → 0x4B800000.
- int_in=16777219:
  - RNE → 0x4B800002.
  - RTZ → 0x4B800001.
- exponent_size=5, mantissa_size=10, int_in=0x7FFFFFFF, is_signed=1:
  - RNE → 0x7C00, overflow=1, inexact=1.
  - RTZ → 0x7BFF.
  - int_in=65519 RNE → 0x7BFF; int_in=65520 RNE → 0x7C00.
- Handshake and reset:
  - int_in=0 → 0x00000000 one cycle after accept.
  - Hold out_ready=0 for 10 cycles → fp stable, in_ready=0; second in_valid ignored.
  - Assert reset mid-NORM → next cycle out_valid=0, in_ready=1, fp=0.

Source files
------------

// File: rtl/int_to_fp_seq_if.sv
// Handshake bundle for the multicycle int-to-FP converter: operand side and result side.
// The master drives operands and result acceptance; the slave is the converter.
interface int_to_fp_seq_if #(
    parameter int int_size      = 32,
    parameter int exponent_size = 8,
    parameter int mantissa_size = 23
);
    localparam int precision = 1 + exponent_size + mantissa_size;

    logic                  in_valid;
    logic                  in_ready;
    logic [int_size-1:0]   int_in;
    logic                  is_signed;
    logic                  rnd_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [precision-1:0]  fp;
    logic                  inexact;
    logic                  overflow;

    modport master (
        output in_valid, int_in, is_signed, rnd_mode, out_ready,
        input  in_ready, out_valid, fp, inexact, overflow
    );

    modport slave (
        input  in_valid, int_in, is_signed, rnd_mode, out_ready,
        output in_ready, out_valid, fp, inexact, overflow
    );
endinterface

// File: rtl/int_to_fp_seq.sv
// Multicycle integer-to-FP converter (RNE/RTZ); latency lz+3 cycles (1 for zero), one in flight.
// in_ready only in IDLE; result and flags held with out_valid until out_ready.
module int_to_fp_seq #(
    parameter int int_size      = 32,
    parameter int exponent_size = 8,
    parameter int mantissa_size = 23
) (
    input  logic            clk,
    input  logic            reset,
    int_to_fp_seq_if.slave  bus
);
    localparam int precision = 1 + exponent_size + mantissa_size;
    localparam int exp_bias  = (1 << (exponent_size - 1)) - 1;
    localparam int EW        = $clog2(int_size) + 1;
    localparam int BW        = ((exponent_size > EW) ? exponent_size : EW) + 2;
    localparam int XW        = int_size + 1 + mantissa_size;
    localparam int MW1       = mantissa_size + 1;

    localparam logic [BW-1:0]            BIASED_LIMIT = BW'((1 << exponent_size) - 1);
    localparam logic [EW-1:0]            EXP_INIT     = EW'(int_size - 1);
    localparam logic [exponent_size-1:0] EXP_ONES     = {exponent_size{1'b1}};
    localparam logic [exponent_size-1:0] EXP_MAXFIN   = {{(exponent_size-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                 state_q,     state_d;
    logic                   sign_q,      sign_d;
    logic [int_size-1:0]    mag_q,       mag_d;
    logic [EW-1:0]          exp_q,       exp_d;
    logic                   rnd_q,       rnd_d;
    logic [precision-1:0]   fp_q,        fp_d;
    logic                   inexact_q,   inexact_d;
    logic                   overflow_q,  overflow_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q,  in_ready_d;

    // Rounding datapath, only consumed in ROUND once mag_q is normalised.
    logic [XW-1:0]            ext;
    logic [mantissa_size-1:0] frac_raw;
    logic [mantissa_size-1:0] frac_rnd;
    logic [MW1-1:0]           frac_sum;
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic                     carry;
    logic [BW-1:0]            biased;
    logic                     exp_ovf;

    always_comb begin
        ext      = {mag_q[int_size-2:0], {(mantissa_size+2){1'b0}}};
        frac_raw = ext[XW-1 -: mantissa_size];
        guard    = ext[XW-1-mantissa_size];
        sticky   = |ext[XW-2-mantissa_size:0];
        round_up = ~rnd_q & guard & (sticky | frac_raw[0]);
        frac_sum = {1'b0, frac_raw} + MW1'(round_up);
        carry    = frac_sum[mantissa_size];
        frac_rnd = frac_sum[mantissa_size-1:0];
        biased   = BW'(exp_bias) + BW'(exp_q) + BW'(carry);
        exp_ovf  = (biased >= BIASED_LIMIT);
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        rnd_d       = rnd_q;
        fp_d        = fp_q;
        inexact_d   = inexact_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d     = bus.is_signed & bus.int_in[int_size-1];
                    mag_d      = sign_d ? ((~bus.int_in) + int_size'(1)) : bus.int_in;
                    exp_d      = EXP_INIT;
                    rnd_d      = bus.rnd_mode;
                    in_ready_d = 1'b0;
                    if (bus.int_in == '0) begin
                        // Zero is always +0, even for signed operands.
                        fp_d        = '0;
                        inexact_d   = 1'b0;
                        overflow_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (!mag_q[int_size-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EW'(1);
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                inexact_d  = guard | sticky;
                overflow_d = exp_ovf;
                if (exp_ovf) begin
                    inexact_d = 1'b1;
                    if (rnd_q)
                        fp_d = {sign_q, EXP_MAXFIN, {mantissa_size{1'b1}}};
                    else
                        fp_d = {sign_q, EXP_ONES, {mantissa_size{1'b0}}};
                end else begin
                    fp_d = {sign_q, biased[exponent_size-1:0], frac_rnd};
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
            rnd_q       <= 1'b0;
            fp_q        <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            rnd_q       <= rnd_d;
            fp_q        <= fp_d;
            inexact_q   <= inexact_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fp        = fp_q;
    assign bus.inexact   = inexact_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed bench: single-precision and half-precision converters sharing one clock,
// checking results, flags, latency, backpressure hold and mid-transaction reset.
module tb_int_to_fp_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int_to_fp_seq_if #(.int_size(32), .exponent_size(8), .mantissa_size(23)) a_if ();
    int_to_fp_seq_if #(.int_size(32), .exponent_size(5), .mantissa_size(10)) h_if ();

    int_to_fp_seq #(.int_size(32), .exponent_size(8), .mantissa_size(23)) dut_sp (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    int_to_fp_seq #(.int_size(32), .exponent_size(5), .mantissa_size(10)) dut_hp (
        .clk(clk), .reset(reset), .bus(h_if.slave));

    // Shared drivers steered to one converter by sel (0: single, 1: half).
    logic        sel;
    logic        drv_valid, drv_ready, drv_sgn, drv_rtz;
    logic [31:0] drv_int;

    assign a_if.in_valid  = drv_valid & ~sel;
    assign h_if.in_valid  = drv_valid & sel;
    assign a_if.out_ready = drv_ready & ~sel;
    assign h_if.out_ready = drv_ready & sel;
    assign a_if.int_in    = drv_int;
    assign h_if.int_in    = drv_int;
    assign a_if.is_signed = drv_sgn;
    assign h_if.is_signed = drv_sgn;
    assign a_if.rnd_mode  = drv_rtz;
    assign h_if.rnd_mode  = drv_rtz;

    logic        obs_in_ready, obs_out_valid, obs_inx, obs_ovf;
    logic [31:0] obs_fp;
    assign obs_in_ready  = sel ? h_if.in_ready  : a_if.in_ready;
    assign obs_out_valid = sel ? h_if.out_valid : a_if.out_valid;
    assign obs_fp        = sel ? {16'h0, h_if.fp} : a_if.fp;
    assign obs_inx       = sel ? h_if.inexact  : a_if.inexact;
    assign obs_ovf       = sel ? h_if.overflow : a_if.overflow;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          half;
        logic [31:0] v;
        bit          sgn;
        bit          rtz;
        logic [31:0] fp;
        bit          inx;
        bit          ovf;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic run_conv(input bit half, input logic [31:0] v, input bit sgn, input bit rtz,
                            output logic [31:0] fp, output bit inx, output bit ovf, output int lat);
        int w;
        sel     = half;
        drv_int = v;
        drv_sgn = sgn;
        drv_rtz = rtz;
        w = 0;
        while (!obs_in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) chk("in_ready_timeout", 64'(obs_in_ready), 64'd1);
        drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 1;
        while (!obs_out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        fp  = obs_fp;
        inx = obs_inx;
        ovf = obs_ovf;
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_fp;
        bit          r_inx, r_ovf;
        int          r_lat;

        reset = 1'b1; sel = 1'b0;
        drv_valid = 1'b0; drv_ready = 1'b0; drv_int = '0; drv_sgn = 1'b0; drv_rtz = 1'b0;

        vecs.push_back('{"one",          0, 32'h00000001, 1, 0, 32'h3F800000, 0, 0, 34});
        vecs.push_back('{"neg_one",      0, 32'hFFFFFFFF, 1, 0, 32'hBF800000, 0, 0, 34});
        vecs.push_back('{"u32_max",      0, 32'hFFFFFFFF, 0, 0, 32'h4F800000, 1, 0, 3});
        vecs.push_back('{"most_neg",     0, 32'h80000000, 1, 0, 32'hCF000000, 0, 0, 3});
        vecs.push_back('{"u_2p31",       0, 32'h80000000, 0, 0, 32'h4F000000, 0, 0, 3});
        vecs.push_back('{"p24p1_rne",    0, 32'd16777217, 1, 0, 32'h4B800000, 1, 0, 10});
        vecs.push_back('{"p24p1_rtz",    0, 32'd16777217, 1, 1, 32'h4B800000, 1, 0, 10});
        vecs.push_back('{"p24p3_rne",    0, 32'd16777219, 1, 0, 32'h4B800002, 1, 0, 10});
        vecs.push_back('{"p24p3_rtz",    0, 32'd16777219, 1, 1, 32'h4B800001, 1, 0, 10});
        vecs.push_back('{"zero",         0, 32'h00000000, 1, 0, 32'h00000000, 0, 0, 1});
        vecs.push_back('{"h_big_rne",    1, 32'h7FFFFFFF, 1, 0, 32'h00007C00, 1, 1, 4});
        vecs.push_back('{"h_big_rtz",    1, 32'h7FFFFFFF, 1, 1, 32'h00007BFF, 1, 1, 4});
        vecs.push_back('{"h_negbig_rtz", 1, 32'h80000001, 1, 1, 32'h0000FBFF, 1, 1, 4});
        vecs.push_back('{"h_65519",      1, 32'd65519,    0, 0, 32'h00007BFF, 1, 0, 19});
        vecs.push_back('{"h_65520",      1, 32'd65520,    0, 0, 32'h00007C00, 1, 1, 19});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sp_in_ready",  64'(a_if.in_ready),  64'd1);
        chk("rst_sp_out_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_sp_fp",        64'(a_if.fp),        64'd0);
        chk("rst_sp_flags",     64'({a_if.inexact, a_if.overflow}), 64'd0);
        chk("rst_hp_in_ready",  64'(h_if.in_ready),  64'd1);
        chk("rst_hp_out_valid", 64'(h_if.out_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_conv(vecs[i].half, vecs[i].v, vecs[i].sgn, vecs[i].rtz, r_fp, r_inx, r_ovf, r_lat);
            chk({vecs[i].name, "_fp"},  64'(r_fp),  64'(vecs[i].fp));
            chk({vecs[i].name, "_inx"}, 64'(r_inx), 64'(vecs[i].inx));
            chk({vecs[i].name, "_ovf"}, 64'(r_ovf), 64'(vecs[i].ovf));
            chk({vecs[i].name, "_lat"}, 64'(r_lat), 64'(vecs[i].lat));
        end

        // Backpressure: result must hold while a second request is ignored.
        sel = 1'b0; drv_int = 32'd5; drv_sgn = 1'b1; drv_rtz = 1'b0;
        drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_int = 32'd7;
        r_lat = 1;
        while (!obs_out_valid && r_lat < 200) begin
            @(posedge clk); #1; r_lat++;
        end
        chk("hold_lat", 64'(r_lat), 64'd32);
        for (int c = 0; c < 10; c++) begin
            chk("hold_fp",        64'(obs_fp),        64'h40A00000);
            chk("hold_in_ready",  64'(obs_in_ready),  64'd0);
            chk("hold_out_valid", 64'(obs_out_valid), 64'd1);
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
        chk("release_out_valid", 64'(obs_out_valid), 64'd0);
        chk("release_in_ready",  64'(obs_in_ready),  64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_phantom_valid", 64'(obs_out_valid), 64'd0);
        end

        // Reset while normalising drops the transaction.
        drv_int = 32'd1; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_norm_busy", 64'(obs_in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_norm_out_valid", 64'(obs_out_valid), 64'd0);
        chk("rst_norm_in_ready",  64'(obs_in_ready),  64'd1);
        chk("rst_norm_fp",        64'(obs_fp),        64'd0);
        run_conv(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, r_fp, r_inx, r_ovf, r_lat);
        chk("after_rst_fp", 64'(r_fp), 64'hBF800000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
